// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Groups the EXE->MEM handshake, the data-SRAM response, the MEM->WB handshake
// and the ID bypass/stall signals of the MEM stage.
//   es2ms_valid/es2ms_bus/ms_allowin    : EXE -> MEM instruction handoff
//   data_sram_data_ok/data_sram_rdata   : data-SRAM response strobe and data
//   ms2ws_valid/ms2ws_bus/ws_allowin    : MEM -> WB instruction handoff
//   ms_fwd_we/ms_fwd_dest/ms_fwd_data   : bypass candidate for ID
//   ms_ld_pending                       : load still waiting for its data
// Modports: master = surrounding pipeline, slave = mem_stage.
// -----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int ES2MS_W = 75,
    parameter int MS2WS_W = 70
);
    logic               es2ms_valid;
    logic               ms_allowin;
    logic [ES2MS_W-1:0] es2ms_bus;
    logic               data_sram_data_ok;
    logic [31:0]        data_sram_rdata;
    logic               ws_allowin;
    logic               ms2ws_valid;
    logic [MS2WS_W-1:0] ms2ws_bus;
    logic               ms_fwd_we;
    logic [4:0]         ms_fwd_dest;
    logic [31:0]        ms_fwd_data;
    logic               ms_ld_pending;

    modport master (
        output es2ms_valid, es2ms_bus, data_sram_data_ok, data_sram_rdata, ws_allowin,
        input  ms_allowin, ms2ws_valid, ms2ws_bus, ms_fwd_we, ms_fwd_dest, ms_fwd_data,
               ms_ld_pending
    );

    modport slave (
        input  es2ms_valid, es2ms_bus, data_sram_data_ok, data_sram_rdata, ws_allowin,
        output ms_allowin, ms2ws_valid, ms2ws_bus, ms_fwd_we, ms_fwd_dest, ms_fwd_data,
               ms_ld_pending
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage LoongArch pipeline (between EXE and WB).
// Holds one instruction; if EXE issued a data-SRAM request it waits for the
// data_ok strobe, then aligns and extends load data (ld.b/bu/h/hu/w) and
// offers the final result to WB. Also drives bypass/stall info for ID.
// Ports:
//   clk     : clock, all state on the rising edge
//   resetn  : asynchronous active-low reset
//   bus     : mem_stage_if.slave (EXE handoff, SRAM response, WB handoff,
//             bypass outputs)
// es2ms_bus = {pc[31:0], result[31:0], mem_req, res_from_mem, ld_op[2:0],
//              dest[4:0], gr_we}
// ms2ws_bus = {pc[31:0], final_result[31:0], dest[4:0], gr_we}
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ES2MS_W = 75,
    parameter int MS2WS_W = 70
) (
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave bus
);

    logic               ms_valid_q,  ms_valid_d;
    logic               data_ok_q,   data_ok_d;
    logic [31:0]        rdata_buf_q, rdata_buf_d;
    logic [ES2MS_W-1:0] es_bus_q,    es_bus_d;

    logic [31:0] pc;
    logic [31:0] result;
    logic        mem_req;
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic [4:0]  dest;
    logic        gr_we;

    logic               ms_ready_go;
    logic               ms_allowin;
    logic               capture;
    logic [31:0]        rd;
    logic [31:0]        final_result;
    logic [MS2WS_W-1:0] ms2ws_bus_w;

    assign {pc, result, mem_req, res_from_mem, ld_op, dest, gr_we} = es_bus_q;

    // Align and extend load data; ld_op 101-111 fall back to a word load.
    function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] data);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] ext;
        case (a)
            2'd0:    byte_s = data[7:0];
            2'd1:    byte_s = data[15:8];
            2'd2:    byte_s = data[23:16];
            default: byte_s = data[31:24];
        endcase
        half_s = a[1] ? data[31:16] : data[15:0];
        case (op)
            3'b001:  ext = byte_s;                 // signed widening sign-extends
            3'b010:  ext = {24'd0, byte_s};        // concatenation zero-extends
            3'b011:  ext = half_s;
            3'b100:  ext = {16'd0, half_s};
            default: ext = data;
        endcase
        return ext;
    endfunction

    // A live data_ok is usable combinationally so a load can retire the
    // same cycle its response arrives.
    assign ms_ready_go = ~mem_req | data_ok_q | bus.data_sram_data_ok;
    assign ms_allowin  = ~ms_valid_q | (ms_ready_go & bus.ws_allowin);

    // Only buffer the response when WB stalls us; otherwise it is consumed
    // on the way out and nothing needs to be remembered.
    assign capture = bus.data_sram_data_ok & ms_valid_q & mem_req & ~data_ok_q
                   & ~bus.ws_allowin;

    assign rd           = data_ok_q ? rdata_buf_q : bus.data_sram_rdata;
    assign final_result = res_from_mem ? load_extract(ld_op, result[1:0], rd) : result;
    assign ms2ws_bus_w  = {pc, final_result, dest, gr_we};

    always_comb begin
        ms_valid_d  = ms_valid_q;
        data_ok_d   = data_ok_q;
        rdata_buf_d = rdata_buf_q;
        es_bus_d    = es_bus_q;
        if (capture) begin
            data_ok_d   = 1'b1;
            rdata_buf_d = bus.data_sram_rdata;
        end
        if (ms_allowin) begin
            ms_valid_d = bus.es2ms_valid;
            // The held response belongs to the departing instruction.
            data_ok_d  = 1'b0;
            if (bus.es2ms_valid) begin
                es_bus_d = bus.es2ms_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            data_ok_q   <= 1'b0;
            rdata_buf_q <= '0;
            es_bus_q    <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            data_ok_q   <= data_ok_d;
            rdata_buf_q <= rdata_buf_d;
            es_bus_q    <= es_bus_d;
        end
    end

    assign bus.ms_allowin    = ms_allowin;
    assign bus.ms2ws_valid   = ms_valid_q & ms_ready_go;
    assign bus.ms2ws_bus     = ms2ws_bus_w;
    assign bus.ms_fwd_we     = ms_valid_q & gr_we;
    assign bus.ms_fwd_dest   = dest;
    assign bus.ms_fwd_data   = final_result;
    assign bus.ms_ld_pending = ms_valid_q & res_from_mem & ~ms_ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// stream compared against a behavioural model of the MEM slot.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic clk;
    logic resetn;
    int   checks;
    int   passes;

    mem_stage_if #(.ES2MS_W(75), .MS2WS_W(70)) bus_if();

    mem_stage #(.ES2MS_W(75), .MS2WS_W(70)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [74:0] pack_es(input logic [31:0] pc, input logic [31:0] res,
                                            input logic mreq, input logic rfm,
                                            input logic [2:0] op, input logic [4:0] dst,
                                            input logic we);
        return {pc, res, mreq, rfm, op, dst, we};
    endfunction

    // Reference load result computed from byte/halfword arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata, input logic rfm);
        int unsigned b;
        int unsigned h;
        if (!rfm) return addr;
        b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        h = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] out_result();
        logic [69:0] v;
        v = bus_if.ms2ws_bus;
        return v[37:6];
    endfunction

    task automatic idle_inputs();
        bus_if.es2ms_valid       = 1'b0;
        bus_if.es2ms_bus         = '0;
        bus_if.data_sram_data_ok = 1'b0;
        bus_if.data_sram_rdata   = '0;
        bus_if.ws_allowin        = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        bus_if.es2ms_valid = 1'b1;
        bus_if.es2ms_bus   = pack_es(32'h1c000000, 32'h1, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus_if.ms_allowin !== 1'b1) $display("FAIL reset_allowin got %b exp 1", bus_if.ms_allowin); else passes++;
        checks++; if (bus_if.ms2ws_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus_if.ms2ws_valid); else passes++;
        checks++; if (bus_if.ms_fwd_we !== 1'b0) $display("FAIL reset_fwd_we got %b exp 0", bus_if.ms_fwd_we); else passes++;
        checks++; if (bus_if.ms_ld_pending !== 1'b0) $display("FAIL reset_pending got %b exp 0", bus_if.ms_ld_pending); else passes++;
        checks++; if (bus_if.ms2ws_bus !== 70'd0) $display("FAIL reset_bus got %h exp 0", bus_if.ms2ws_bus); else passes++;
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_alu();
        @(negedge clk);
        idle_inputs();
        bus_if.es2ms_valid = 1'b1;
        bus_if.es2ms_bus   = pack_es(32'h1c000010, 32'h12345678, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1);
        @(negedge clk);
        bus_if.es2ms_valid = 1'b0;
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b1) $display("FAIL alu_valid got %b exp 1", bus_if.ms2ws_valid); else passes++;
        checks++; if (out_result() !== 32'h12345678) $display("FAIL alu_result got %h exp 12345678", out_result()); else passes++;
        checks++; if (bus_if.ms_fwd_we !== 1'b1) $display("FAIL alu_fwd_we got %b exp 1", bus_if.ms_fwd_we); else passes++;
        checks++; if (bus_if.ms_fwd_dest !== 5'd5) $display("FAIL alu_fwd_dest got %0d exp 5", bus_if.ms_fwd_dest); else passes++;
        checks++; if (bus_if.ms_ld_pending !== 1'b0) $display("FAIL alu_pending got %b exp 0", bus_if.ms_ld_pending); else passes++;
        @(negedge clk);
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b0) $display("FAIL alu_retired got %b exp 0", bus_if.ms2ws_valid); else passes++;
    endtask

    task automatic test_ld_b_wait();
        @(negedge clk);
        idle_inputs();
        bus_if.es2ms_valid = 1'b1;
        bus_if.es2ms_bus   = pack_es(32'h1c000020, 32'h00001003, 1'b1, 1'b1, 3'd1, 5'd7, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_if.es2ms_valid = 1'b0;
            #1;
            checks++; if (bus_if.ms_ld_pending !== 1'b1) $display("FAIL ldb_pending c%0d got %b exp 1", i, bus_if.ms_ld_pending); else passes++;
            checks++; if (bus_if.ms2ws_valid !== 1'b0) $display("FAIL ldb_wait_valid c%0d got %b exp 0", i, bus_if.ms2ws_valid); else passes++;
        end
        @(negedge clk);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h80FF1234;
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b1) $display("FAIL ldb_valid got %b exp 1", bus_if.ms2ws_valid); else passes++;
        checks++; if (out_result() !== 32'hFFFFFF80) $display("FAIL ldb_result got %h exp ffffff80", out_result()); else passes++;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b0) $display("FAIL ldb_retired got %b exp 0", bus_if.ms2ws_valid); else passes++;
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input string nm);
        @(negedge clk);
        idle_inputs();
        bus_if.es2ms_valid = 1'b1;
        bus_if.es2ms_bus   = pack_es(32'h1c000040, addr, 1'b1, 1'b1, op, 5'd9, 1'b1);
        @(negedge clk);
        bus_if.es2ms_valid       = 1'b0;
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = rdata;
        #1;
        checks++; if (out_result() !== exp || bus_if.ms2ws_valid !== 1'b1)
            $display("FAIL %s got %h (valid %b) exp %h", nm, out_result(), bus_if.ms2ws_valid, exp); else passes++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_load_extract();
        do_load(3'd3, 32'h00002002, 32'h8001ABCD, 32'hFFFF8001, "ld_h");
        do_load(3'd4, 32'h00002002, 32'h8001ABCD, 32'h00008001, "ld_hu");
        do_load(3'd2, 32'h00002001, 32'h8001ABCD, 32'h000000AB, "ld_bu");
        do_load(3'd0, 32'h00002000, 32'h8001ABCD, 32'h8001ABCD, "ld_w");
        do_load(3'd6, 32'h00002000, 32'h5A5A0101, 32'h5A5A0101, "ld_op6_word");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        idle_inputs();
        bus_if.es2ms_valid = 1'b1;
        bus_if.es2ms_bus   = pack_es(32'h1c000060, 32'h00003000, 1'b1, 1'b1, 3'd0, 5'd11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_if.es2ms_valid       = 1'b0;
            bus_if.ws_allowin        = 1'b0;
            bus_if.data_sram_data_ok = (i == 0);
            bus_if.data_sram_rdata   = (i == 0) ? 32'hDEADBEEF : $urandom();
            #1;
            checks++; if (bus_if.ms_allowin !== 1'b0) $display("FAIL bp_allowin c%0d got %b exp 0", i, bus_if.ms_allowin); else passes++;
            checks++; if (bus_if.ms2ws_valid !== 1'b1) $display("FAIL bp_valid c%0d got %b exp 1", i, bus_if.ms2ws_valid); else passes++;
            checks++; if (out_result() !== 32'hDEADBEEF) $display("FAIL bp_result c%0d got %h exp deadbeef", i, out_result()); else passes++;
        end
        @(negedge clk);
        bus_if.ws_allowin      = 1'b1;
        bus_if.data_sram_rdata = 32'h01234567;
        #1;
        checks++; if (out_result() !== 32'hDEADBEEF || bus_if.ms_allowin !== 1'b1)
            $display("FAIL bp_release got %h allowin %b exp deadbeef 1", out_result(), bus_if.ms_allowin); else passes++;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b0) $display("FAIL bp_retired got %b exp 0", bus_if.ms2ws_valid); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        for (int i = 0; i < 4; i++) vals[i] = $urandom();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            idle_inputs();
            bus_if.data_sram_data_ok = 1'b1;   // spurious: no request outstanding
            bus_if.data_sram_rdata   = 32'hBAD0BAD0;
            if (i < 4) begin
                bus_if.es2ms_valid = 1'b1;
                bus_if.es2ms_bus   = pack_es(32'h1c000100 + 4 * i, vals[i], 1'b0, 1'b0, 3'd1,
                                             5'(i + 1), 1'b1);
            end
            #1;
            if (i > 0) begin
                checks++; if (bus_if.ms2ws_valid !== 1'b1 || out_result() !== vals[i-1])
                    $display("FAIL b2b_%0d got %h valid %b exp %h", i, out_result(), bus_if.ms2ws_valid, vals[i-1]); else passes++;
                checks++; if (bus_if.ms_allowin !== 1'b1) $display("FAIL b2b_allowin_%0d got %b exp 1", i, bus_if.ms_allowin); else passes++;
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b0) $display("FAIL b2b_drained got %b exp 0", bus_if.ms2ws_valid); else passes++;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        idle_inputs();
        bus_if.es2ms_valid = 1'b1;
        bus_if.es2ms_bus   = pack_es(32'h1c000200, 32'h00004001, 1'b1, 1'b1, 3'd2, 5'd12, 1'b1);
        @(negedge clk);
        bus_if.es2ms_valid = 1'b0;
        #1;
        checks++; if (bus_if.ms_ld_pending !== 1'b1) $display("FAIL rst_wait_pending got %b exp 1", bus_if.ms_ld_pending); else passes++;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (bus_if.ms_ld_pending !== 1'b0 || bus_if.ms2ws_valid !== 1'b0 || bus_if.ms_fwd_we !== 1'b0)
            $display("FAIL rst_async got pend %b valid %b we %b exp 0 0 0", bus_if.ms_ld_pending, bus_if.ms2ws_valid, bus_if.ms_fwd_we); else passes++;
        checks++; if (bus_if.ms_allowin !== 1'b1) $display("FAIL rst_async_allowin got %b exp 1", bus_if.ms_allowin); else passes++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus_if.data_sram_data_ok = 1'b1;
        bus_if.data_sram_rdata   = 32'h11223344;
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b0 || bus_if.ms_allowin !== 1'b1)
            $display("FAIL rst_late_ok got valid %b allowin %b exp 0 1", bus_if.ms2ws_valid, bus_if.ms_allowin); else passes++;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus_if.ms2ws_valid !== 1'b0 || bus_if.ms_ld_pending !== 1'b0)
            $display("FAIL rst_after got valid %b pend %b exp 0 0", bus_if.ms2ws_valid, bus_if.ms_ld_pending); else passes++;
    endtask

    // Random stream: the model tracks the instruction in MEM, whether its
    // response arrived and what it was, and the cycles until the SRAM answers.
    task automatic test_random();
        logic        exe_v;
        logic [74:0] exe_bus;
        logic        s_v, s_mreq, s_rfm, s_we, s_seen;
        logic [2:0]  s_op;
        logic [4:0]  s_dst;
        logic [31:0] s_pc, s_res, s_data;
        int          cnt;
        int          retired;
        logic        real_ok, got, ready, exp_valid, leave, exp_allowin;
        logic [31:0] exp_res, rdv;
        logic        m, r;
        exe_v = 1'b0; exe_bus = '0; s_v = 1'b0; s_seen = 1'b0; cnt = 0; retired = 0;
        s_mreq = 1'b0; s_rfm = 1'b0; s_we = 1'b0; s_op = '0; s_dst = '0;
        s_pc = '0; s_res = '0; s_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!exe_v && ($urandom_range(0, 3) != 0)) begin
                m = $urandom_range(0, 1);
                r = m & $urandom_range(0, 1);
                exe_bus = pack_es($urandom(), $urandom(), m, r, 3'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 31)), m ? r : 1'($urandom_range(0, 1)));
                exe_v = 1'b1;
            end
            real_ok = s_v & s_mreq & ~s_seen & (cnt == 0);
            bus_if.es2ms_valid       = exe_v;
            bus_if.es2ms_bus         = exe_bus;
            bus_if.ws_allowin        = ($urandom_range(0, 9) < 7);
            bus_if.data_sram_rdata   = $urandom();
            bus_if.data_sram_data_ok = real_ok |
                (~(s_v & s_mreq & ~s_seen) & ($urandom_range(0, 9) == 0));
            #1;
            got       = s_seen | (s_mreq & bus_if.data_sram_data_ok);
            ready     = ~s_mreq | got;
            exp_valid = s_v & ready;
            rdv       = s_seen ? s_data : bus_if.data_sram_rdata;
            exp_res   = ref_result(s_op, s_res, rdv, s_rfm);
            leave       = exp_valid & bus_if.ws_allowin;
            exp_allowin = ~s_v | leave;
            checks++; if (bus_if.ms2ws_valid !== exp_valid)
                $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, bus_if.ms2ws_valid, exp_valid); else passes++;
            checks++; if (bus_if.ms_allowin !== exp_allowin)
                $display("FAIL rnd_allowin cyc %0d got %b exp %b", cyc, bus_if.ms_allowin, exp_allowin); else passes++;
            checks++; if (bus_if.ms_fwd_we !== (s_v & s_we))
                $display("FAIL rnd_fwd_we cyc %0d got %b exp %b", cyc, bus_if.ms_fwd_we, s_v & s_we); else passes++;
            if (!bus_if.data_sram_data_ok) begin
                checks++; if (bus_if.ms_ld_pending !== (s_v & s_rfm & ~ready))
                    $display("FAIL rnd_pending cyc %0d got %b exp %b", cyc, bus_if.ms_ld_pending, s_v & s_rfm & ~ready); else passes++;
            end
            if (exp_valid) begin
                checks++; if (bus_if.ms2ws_bus !== {s_pc, exp_res, s_dst, s_we})
                    $display("FAIL rnd_bus cyc %0d got %h exp %h", cyc, bus_if.ms2ws_bus, {s_pc, exp_res, s_dst, s_we}); else passes++;
                checks++; if (bus_if.ms_fwd_data !== exp_res || bus_if.ms_fwd_dest !== s_dst)
                    $display("FAIL rnd_fwd cyc %0d got %h/%0d exp %h/%0d", cyc, bus_if.ms_fwd_data, bus_if.ms_fwd_dest, exp_res, s_dst); else passes++;
            end
            if (leave) retired++;
            if (s_v & s_mreq & ~s_seen & bus_if.data_sram_data_ok & ~bus_if.ws_allowin) begin
                s_seen = 1'b1;
                s_data = bus_if.data_sram_rdata;
            end else if (s_v & s_mreq & ~s_seen & (cnt > 0)) begin
                cnt--;
            end
            if (exp_allowin) begin
                s_v = exe_v;
                if (exe_v) begin
                    {s_pc, s_res, s_mreq, s_rfm, s_op, s_dst, s_we} = exe_bus;
                    s_seen = 1'b0;
                    cnt    = $urandom_range(0, 3);
                    exe_v  = 1'b0;
                end
            end
        end
        checks++; if (retired < 500) $display("FAIL rnd_throughput got %0d retired exp >= 500", retired); else passes++;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_alu();
        test_ld_b_wait();
        test_load_extract();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
